intf_adder_channel: RTL and testbench

//  Handshaked operand/result channel carrying two unsigned operands a, b and returning c = a + b.

---
 rtl/intf_adder_channel.sv | 84 ++++++++
 tb/tb_intf_adder_channel.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/intf_adder_channel.sv
// Handshaked a+b channel: sums accepted operand pairs into a small output FIFO and
// counts results popped by the consumer.
module intf_adder_channel #(
    parameter int unsigned AW    = 4,
    parameter int unsigned CW    = 7,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNTW  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [AW-1:0]   a_i,
    input  logic [AW-1:0]   b_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [CW-1:0]   c_o,
    output logic [CNTW-1:0] txn_count_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PtrW:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            run_q;
    logic [CW-1:0]   mem_q [DEPTH];

    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [CW-1:0]   sum;

    always_comb begin
        sum   = CW'(a_i) + CW'(b_i);
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
        // run_q holds ready low while reset is asserted and until the first edge after release.
        in_ready_o  = run_q && !full;
        out_valid_o = !empty;
        push        = in_valid_i && in_ready_o;
        pop         = out_valid_o && out_ready_i;
        c_o         = empty ? '0 : mem_q[rd_ptr_q[PtrW-1:0]];
        txn_count_o = cnt_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + {{PtrW{1'b0}}, 1'b1};
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + {{PtrW{1'b0}}, 1'b1};
            cnt_d    = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            run_q    <= 1'b1;
        end
    end

    // Storage needs no reset: the output mux forces c to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= sum;
        end
    end

endmodule

// File: tb/tb_intf_adder_channel.sv
// Directed bench for intf_adder_channel: reset, boundaries, backpressure, streaming,
// asynchronous reset with queued data and counter wrap.
module tb_intf_adder_channel;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] c;
    logic [7:0] txn_count;

    int n_cmp;
    int n_bad;

    logic [3:0] sa [20];
    logic [3:0] sb [20];
    logic [6:0] se [20];

    intf_adder_channel #(
        .AW   (4),
        .CW   (7),
        .DEPTH(2),
        .CNTW (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .a_i        (a),
        .b_i        (b),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .c_o        (c),
        .txn_count_o(txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Returns 1 time unit after a rising edge: inputs driven here, outputs settled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single accepted transfer with the consumer ready; result checked then popped.
    task automatic xfer(input string tag, input logic [3:0] xa, input logic [3:0] xb,
                        input logic [6:0] exp);
        a = xa; b = xb; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_c"}, 32'(c), 32'(exp));
        step();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;

        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_c", 32'(c), 32'd0);
        check("rst_txn", 32'(txn_count), 32'd0);
        step();
        check("rst_held_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        check("rel_in_ready_pre", 32'(in_ready), 32'd0);
        step();
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Basic 6+4
        out_ready = 1'b1;
        xfer("t1", 4'd6, 4'd4, 7'd10);
        check("t1_txn", 32'(txn_count), 32'd1);
        check("t1_empty", 32'(out_valid), 32'd0);

        // Boundaries
        xfer("max", 4'd15, 4'd15, 7'd30);
        xfer("zero", 4'd0, 4'd0, 7'd0);
        xfer("fz", 4'd15, 4'd0, 7'd15);
        check("t2_txn", 32'(txn_count), 32'd4);

        // Backpressure: fill both entries, stall, then drain
        out_ready = 1'b0;
        a = 4'd3; b = 4'd4; in_valid = 1'b1;
        step();
        a = 4'd5; b = 4'd6;
        step();
        in_valid = 1'b0;
        check("bp_full_ready", 32'(in_ready), 32'd0);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_c", 32'(c), 32'd7);
        step();
        step();
        check("bp_hold_c", 32'(c), 32'd7);
        check("bp_hold_txn", 32'(txn_count), 32'd4);
        out_ready = 1'b1;
        check("bp_no_bypass", 32'(in_ready), 32'd0);
        step();
        check("bp_c2", 32'(c), 32'd11);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        step();
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_txn", 32'(txn_count), 32'd6);
        step();
        check("empty_no_pop", 32'(txn_count), 32'd6);

        // Streaming: push and pop every cycle
        for (int i = 0; i < 20; i++) begin
            sa[i] = 4'($urandom_range(0, 15));
            sb[i] = 4'($urandom_range(0, 15));
            se[i] = 7'(sa[i]) + 7'(sb[i]);
        end
        for (int i = 0; i < 20; i++) begin
            a = sa[i]; b = sb[i]; in_valid = 1'b1;
            step();
            check($sformatf("st_c%0d", i), 32'(c), 32'(se[i]));
            check($sformatf("st_rdy%0d", i), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("st_txn", 32'(txn_count), 32'd26);
        check("st_empty", 32'(out_valid), 32'd0);

        // Async reset with two results queued
        out_ready = 1'b0;
        a = 4'd1; b = 4'd2; in_valid = 1'b1;
        step();
        a = 4'd7; b = 4'd8;
        step();
        in_valid = 1'b0;
        check("ar_queued", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_c", 32'(c), 32'd0);
        check("ar_txn", 32'(txn_count), 32'd0);
        check("ar_ready", 32'(in_ready), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("ar_rel_ready", 32'(in_ready), 32'd1);
        check("ar_rel_valid", 32'(out_valid), 32'd0);

        // Counter wrap over 256 pops
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a = 4'(i); b = 4'(i >> 4); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check("wr_255", 32'(txn_count), 32'd255);
        check("wr_last_c", 32'(c), 32'd30);
        step();
        check("wr_0", 32'(txn_count), 32'd0);
        check("wr_empty", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
